// File: rtl/pi_access_splitter.sv
// rtl/pi_access_splitter.sv - splits one Pi byte/word/long access into aligned 68000 bus cycles
// Ports: sys_clk/sys_reset (sync, active-high); req_* Pi request in, done/err/rdata completion out;
//        cyc_* bus-cycle request to the engine (valid/ready), cyc_done/cyc_berr/cyc_rdata back.
module pi_access_splitter #(
    parameter int ADDR_W = 24
) (
    input  logic              sys_clk,
    input  logic              sys_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [1:0]        req_size,
    input  logic              req_read,
    input  logic [2:0]        req_fc,
    input  logic [31:0]       req_wdata,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              cyc_valid,
    input  logic              cyc_ready,
    output logic [ADDR_W-2:0] cyc_addr,
    output logic              cyc_uds,
    output logic              cyc_lds,
    output logic              cyc_read,
    output logic [2:0]        cyc_fc,
    output logic [15:0]       cyc_wdata,
    input  logic              cyc_done,
    input  logic              cyc_berr,
    input  logic [15:0]       cyc_rdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_FINISH = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [1:0]        size_q, size_d;
    logic              read_q, read_d;
    logic [2:0]        fc_q, fc_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        idx_q, idx_d;
    logic [1:0]        ncyc_q, ncyc_d;
    logic [31:0]       asm_q, asm_d;
    logic              err_q, err_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              cvalid_q, cvalid_d;
    logic [ADDR_W-2:0] caddr_q, caddr_d;
    logic              cuds_q, cuds_d;
    logic              clds_q, clds_d;
    logic [15:0]       cwdata_q, cwdata_d;

    // Plan for one bus cycle: from the live request when accepting, else from the
    // latched request at the next index.
    logic [ADDR_W-1:0] p_addr;
    logic [1:0]        p_size;
    logic [31:0]       p_wdata;
    logic [1:0]        p_idx;
    logic [ADDR_W-1:0] p_off;
    logic              p_uds, p_lds;
    logic [15:0]       p_wd;
    logic [1:0]        p_n;
    logic [ADDR_W-1:0] p_byte_addr;
    logic [31:0]       asm_n;

    always_comb begin
        if (state_q == S_IDLE) begin
            p_addr  = req_address;
            p_size  = req_size;
            p_wdata = req_wdata;
            p_idx   = 2'd0;
        end else begin
            p_addr  = addr_q;
            p_size  = size_q;
            p_wdata = wdata_q;
            p_idx   = idx_q + 2'd1;
        end
    end

    always_comb begin
        p_off = '0;
        p_uds = 1'b0;
        p_lds = 1'b0;
        p_wd  = '0;
        p_n   = 2'd0;
        case (p_size)
            2'd0: begin
                // Byte cycles drive the byte on both lanes.
                p_n   = 2'd1;
                p_uds = ~p_addr[0];
                p_lds = p_addr[0];
                p_wd  = {p_wdata[7:0], p_wdata[7:0]};
            end
            2'd1: begin
                if (!p_addr[0]) begin
                    p_n   = 2'd1;
                    p_uds = 1'b1;
                    p_lds = 1'b1;
                    p_wd  = p_wdata[15:0];
                end else begin
                    p_n = 2'd2;
                    if (p_idx == 2'd0) begin
                        p_lds = 1'b1;
                        p_wd  = {p_wdata[15:8], p_wdata[15:8]};
                    end else begin
                        p_off = ADDR_W'(1);
                        p_uds = 1'b1;
                        p_wd  = {p_wdata[7:0], p_wdata[7:0]};
                    end
                end
            end
            2'd2: begin
                if (!p_addr[0]) begin
                    p_n   = 2'd2;
                    p_uds = 1'b1;
                    p_lds = 1'b1;
                    if (p_idx == 2'd0) begin
                        p_wd = p_wdata[31:16];
                    end else begin
                        p_off = ADDR_W'(2);
                        p_wd  = p_wdata[15:0];
                    end
                end else begin
                    p_n = 2'd3;
                    case (p_idx)
                        2'd0: begin
                            p_lds = 1'b1;
                            p_wd  = {p_wdata[31:24], p_wdata[31:24]};
                        end
                        2'd1: begin
                            p_off = ADDR_W'(1);
                            p_uds = 1'b1;
                            p_lds = 1'b1;
                            p_wd  = p_wdata[23:8];
                        end
                        default: begin
                            p_off = ADDR_W'(3);
                            p_uds = 1'b1;
                            p_wd  = {p_wdata[7:0], p_wdata[7:0]};
                        end
                    endcase
                end
            end
            default: ;
        endcase
    end

    // Adding in full ADDR_W width gives the modulo-2^ADDR_W wrap for free.
    assign p_byte_addr = p_addr + p_off;

    // Read data is shifted in from the right, so earlier (lower-address) bytes end up
    // more significant and the result is right-justified.
    always_comb begin
        asm_n = asm_q;
        if (read_q) begin
            if (cuds_q && clds_q) begin
                asm_n = {asm_q[15:0], cyc_rdata};
            end else if (cuds_q) begin
                asm_n = {asm_q[23:0], cyc_rdata[15:8]};
            end else begin
                asm_n = {asm_q[23:0], cyc_rdata[7:0]};
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        size_d   = size_q;
        read_d   = read_q;
        fc_d     = fc_q;
        wdata_d  = wdata_q;
        idx_d    = idx_q;
        ncyc_d   = ncyc_q;
        asm_d    = asm_q;
        err_d    = err_q;
        rdata_d  = rdata_q;
        cvalid_d = cvalid_q;
        caddr_d  = caddr_q;
        cuds_d   = cuds_q;
        clds_d   = clds_q;
        cwdata_d = cwdata_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_address;
                    size_d  = req_size;
                    read_d  = req_read;
                    fc_d    = req_fc;
                    wdata_d = req_wdata;
                    idx_d   = 2'd0;
                    ncyc_d  = p_n;
                    asm_d   = '0;
                    err_d   = 1'b0;
                    if (req_size == 2'd3) begin
                        // Reserved size: one idle cycle in WAIT, no bus cycle issued.
                        state_d = S_WAIT;
                    end else begin
                        state_d  = S_ISSUE;
                        cvalid_d = 1'b1;
                        caddr_d  = p_byte_addr[ADDR_W-1:1];
                        cuds_d   = p_uds;
                        clds_d   = p_lds;
                        cwdata_d = p_wd;
                    end
                end
            end
            S_ISSUE: begin
                if (cyc_ready) begin
                    state_d  = S_WAIT;
                    cvalid_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (size_q == 2'd3) begin
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_FINISH;
                end else if (cyc_done) begin
                    if (cyc_berr) begin
                        // Data from the failed cycle is not part of the result.
                        err_d   = 1'b1;
                        rdata_d = asm_q;
                        state_d = S_FINISH;
                    end else if (idx_q + 2'd1 == ncyc_q) begin
                        asm_d   = asm_n;
                        rdata_d = asm_n;
                        state_d = S_FINISH;
                    end else begin
                        asm_d    = asm_n;
                        idx_d    = idx_q + 2'd1;
                        state_d  = S_ISSUE;
                        cvalid_d = 1'b1;
                        caddr_d  = p_byte_addr[ADDR_W-1:1];
                        cuds_d   = p_uds;
                        clds_d   = p_lds;
                        cwdata_d = p_wd;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            size_q   <= '0;
            read_q   <= 1'b0;
            fc_q     <= '0;
            wdata_q  <= '0;
            idx_q    <= '0;
            ncyc_q   <= '0;
            asm_q    <= '0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
            cvalid_q <= 1'b0;
            caddr_q  <= '0;
            cuds_q   <= 1'b0;
            clds_q   <= 1'b0;
            cwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            size_q   <= size_d;
            read_q   <= read_d;
            fc_q     <= fc_d;
            wdata_q  <= wdata_d;
            idx_q    <= idx_d;
            ncyc_q   <= ncyc_d;
            asm_q    <= asm_d;
            err_q    <= err_d;
            rdata_q  <= rdata_d;
            cvalid_q <= cvalid_d;
            caddr_q  <= caddr_d;
            cuds_q   <= cuds_d;
            clds_q   <= clds_d;
            cwdata_q <= cwdata_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign done      = (state_q == S_FINISH);
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign cyc_valid = cvalid_q;
    assign cyc_addr  = caddr_q;
    assign cyc_uds   = cuds_q;
    assign cyc_lds   = clds_q;
    assign cyc_read  = read_q;
    assign cyc_fc    = fc_q;
    assign cyc_wdata = cwdata_q;

endmodule
